// File: rtl/fb_link_pkg.sv
// Shared types, defaults and the colour-bar byte for the serial loader.
// Exports state_t, default parameters and pat_byte().
package fb_link_pkg;

  localparam int HALF_DEF        = 4;
  localparam int RST_CYCLES_DEF  = 8;
  localparam int FRAME_BYTES_DEF = 8192;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LINK_RST,
    ST_GUARD,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_t;

  // Colour bars: bits [6:4] of the byte address, repeated per nibble.
  function automatic logic [7:0] pat_byte(input logic [2:0] sel);
    return {1'b0, sel, 1'b0, sel};
  endfunction

endpackage

// File: rtl/fb_bit_shifter.sv
// MSB-first byte shifter with per-bit phase counter.
// Ports: clk, reset_n, en, load, din -> tgl, upd, bit_val, done.
module fb_bit_shifter #(
  parameter int HALF = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       load,
  input  logic [7:0] din,
  output logic       tgl,
  output logic       upd,
  output logic       bit_val,
  output logic       done
);

  localparam logic [8:0] PH_MID  = 9'(HALF - 1);
  localparam logic [8:0] PH_LAST = 9'(2 * HALF - 1);

  logic [7:0] sr_q, sr_d;
  logic [2:0] bit_q, bit_d;
  logic [8:0] ph_q, ph_d;
  logic       bit_end;

  // sr_q holds the bits still to be sent, next one in [7].
  always_comb begin
    sr_d  = sr_q;
    bit_d = bit_q;
    ph_d  = ph_q;
    if (load) begin
      sr_d  = {din[6:0], 1'b0};
      bit_d = 3'd0;
      ph_d  = 9'd0;
    end else if (en) begin
      if (ph_q == PH_LAST) begin
        ph_d  = 9'd0;
        bit_d = bit_q + 3'd1;
        sr_d  = {sr_q[6:0], 1'b0};
      end else begin
        ph_d = ph_q + 9'd1;
      end
    end
  end

  assign bit_end = en && (ph_q == PH_LAST);
  assign tgl     = en && (ph_q == PH_MID);
  assign done    = bit_end && (bit_q == 3'd7);
  assign upd     = load || (bit_end && !done);
  assign bit_val = load ? din[7] : sr_q[7];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sr_q  <= '0;
      bit_q <= '0;
      ph_q  <= '0;
    end else begin
      sr_q  <= sr_d;
      bit_q <= bit_d;
      ph_q  <= ph_d;
    end
  end

endmodule

// File: rtl/fb_serial_loader.sv
// Frame loader: link reset, guard, then bytes shifted out on ser_clk edges.
// Ports: start/pat_en, s_valid/s_data/s_ready, ser_clk/data/rst, busy, frame_done, byte_cnt.
module fb_serial_loader
  import fb_link_pkg::*;
#(
  parameter int HALF        = HALF_DEF,
  parameter int RST_CYCLES  = RST_CYCLES_DEF,
  parameter int FRAME_BYTES = FRAME_BYTES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        pat_en,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic        ser_clk,
  output logic        ser_data,
  output logic        ser_rst,
  output logic        busy,
  output logic        frame_done,
  output logic [12:0] byte_cnt
);

  localparam logic [15:0] RST_LAST   = 16'(RST_CYCLES - 1);
  localparam logic [15:0] GUARD_LAST = 16'(HALF - 1);
  localparam logic [13:0] FB_LAST    = 14'(FRAME_BYTES);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        pat_q, pat_d;
  logic [12:0] byte_cnt_q, byte_cnt_d;
  logic        ser_clk_q, ser_clk_d;
  logic        ser_data_q, ser_data_d;
  logic        ser_rst_q, ser_rst_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        sh_load, sh_tgl, sh_upd, sh_bit, sh_done;
  logic [7:0]  sh_din;
  logic [13:0] next_cnt;

  assign next_cnt = {1'b0, byte_cnt_q} + 14'd1;

  fb_bit_shifter #(
    .HALF (HALF)
  ) u_shift (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (state_q == ST_SHIFT),
    .load    (sh_load),
    .din     (sh_din),
    .tgl     (sh_tgl),
    .upd     (sh_upd),
    .bit_val (sh_bit),
    .done    (sh_done)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pat_q      <= 1'b0;
      byte_cnt_q <= '0;
      ser_clk_q  <= 1'b0;
      ser_data_q <= 1'b0;
      ser_rst_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pat_q      <= pat_d;
      byte_cnt_q <= byte_cnt_d;
      ser_clk_q  <= ser_clk_d;
      ser_data_q <= ser_data_d;
      ser_rst_q  <= ser_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pat_d      = pat_q;
    byte_cnt_d = byte_cnt_q;
    sh_load    = 1'b0;
    sh_din     = s_data;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_LINK_RST;
          cnt_d      = '0;
          pat_d      = pat_en;
          byte_cnt_d = '0;
        end
      end
      ST_LINK_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = ST_GUARD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_GUARD: begin
        if (cnt_q == GUARD_LAST) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_LOAD: begin
        if (pat_q) begin
          sh_din  = pat_byte(byte_cnt_q[6:4]);
          sh_load = 1'b1;
          state_d = ST_SHIFT;
        end else if (s_valid) begin
          sh_load = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (sh_done) begin
          byte_cnt_d = next_cnt[12:0];
          state_d    = (next_cnt == FB_LAST) ? ST_DONE : ST_LOAD;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs registered from the next state so they align with state_q.
  always_comb begin
    ser_rst_d  = (state_d == ST_LINK_RST);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
    ser_data_d = sh_upd ? sh_bit : ser_data_q;
    ser_clk_d  = ser_clk_q ^ sh_tgl;
    if (state_d == ST_LINK_RST || state_d == ST_GUARD) begin
      ser_clk_d = 1'b0;
    end
  end

  assign s_ready    = (state_q == ST_LOAD) && !pat_q;
  assign ser_clk    = ser_clk_q;
  assign ser_data   = ser_data_q;
  assign ser_rst    = ser_rst_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign byte_cnt   = byte_cnt_q;

endmodule

// File: tb/tb_fb_serial_loader.sv
// Directed bench for fb_serial_loader with a link-side byte decoder.
// Small frame (32 bytes) keeps the run short.
module tb_fb_serial_loader;

  localparam int HALF = 4;
  localparam int RSTC = 8;
  localparam int FB   = 32;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        pat_en = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_ready, ser_clk, ser_data, ser_rst;
  logic        busy, frame_done;
  logic [12:0] byte_cnt;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [0:8191];
  int   addr = 0, bits = 0, toggles = 0, rst_rises = 0, fd_cnt = 0;
  logic [7:0] sr = 8'h00;
  logic prev_clk = 1'b0, prev_rst = 1'b0;

  always #5 clk = ~clk;

  fb_serial_loader #(
    .HALF        (HALF),
    .RST_CYCLES  (RSTC),
    .FRAME_BYTES (FB)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .pat_en     (pat_en),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .ser_clk    (ser_clk),
    .ser_data   (ser_data),
    .ser_rst    (ser_rst),
    .busy       (busy),
    .frame_done (frame_done),
    .byte_cnt   (byte_cnt)
  );

  // Receiver model: any ser_clk edge shifts in ser_data; ser_rst clears address.
  always @(negedge clk) begin
    if (ser_rst) begin
      addr = 0;
      bits = 0;
      sr   = 8'h00;
    end else if (ser_clk !== prev_clk) begin
      toggles++;
      sr = {sr[6:0], ser_data};
      bits++;
      if (bits == 8) begin
        mem[addr[12:0]] = sr;
        addr++;
        bits = 0;
      end
    end
    if (ser_rst && !prev_rst) rst_rises++;
    if (frame_done) fd_cnt++;
    prev_clk = ser_clk;
    prev_rst = ser_rst;
  end

  function automatic logic [7:0] pat(input int a);
    return {1'b0, a[6:4], 1'b0, a[6:4]};
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({ser_clk, ser_data, ser_rst, s_ready,
                busy, frame_done, byte_cnt});
  endfunction

  initial begin
    int k, t0, f0, r0, bad;

    // Reset held with start asserted
    reset_n = 1'b0;
    start   = 1'b1;
    pat_en  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_outs", outs(), 32'd0);
    end
    start   = 1'b0;
    reset_n = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // Pattern frame
    t0 = toggles; f0 = fd_cnt; r0 = rst_rises;
    start = 1'b1; pat_en = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (ser_rst && k < 100) begin k++; tick(); end
    chk("rst_len", 32'(k), 32'd8);
    chk("guard_busy", 32'(busy), 32'd1);
    k = 0;
    while (!ser_clk && k < 100) begin tick(); k++; end
    chk("first_toggle", 32'(k), 32'd9);

    // Start while busy must be ignored
    repeat (300) tick();
    start = 1'b1; pat_en = 1'b0;
    tick();
    start = 1'b0;
    k = 0;
    while (!frame_done && k < 5000) begin tick(); k++; end
    chk("frame_done_seen", 32'(frame_done), 32'd1);
    tick();
    chk("end_byte_cnt", 32'(byte_cnt), 32'(FB));
    chk("end_busy", 32'(busy), 32'd0);
    repeat (5) tick();
    chk("done_pulses", 32'(fd_cnt - f0), 32'd1);
    chk("toggle_count", 32'(toggles - t0), 32'(FB * 8));
    chk("rst_count", 32'(rst_rises - r0), 32'd1);
    chk("decoded_bytes", 32'(addr), 32'(FB));
    chk("byte0", 32'(mem[0]), 32'h00);
    chk("byte16", 32'(mem[16]), 32'h11);
    bad = 0;
    for (int i = 0; i < FB; i++)
      if (mem[i] !== pat(i)) bad++;
    chk("pattern_all", 32'(bad), 32'd0);

    // External stream with a long stall
    start = 1'b1; pat_en = 1'b0;
    tick();
    start = 1'b0;
    k = 0;
    while (!s_ready && k < 100) begin tick(); k++; end
    chk("ext_ready", 32'(s_ready), 32'd1);
    t0 = toggles; bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (s_ready !== 1'b1) bad++;
    end
    chk("stall_ready", 32'(bad), 32'd0);
    chk("stall_toggles", 32'(toggles - t0), 32'd0);
    s_valid = 1'b1; s_data = 8'hA5;
    tick();
    s_valid = 1'b0;
    chk("shift_not_ready", 32'(s_ready), 32'd0);
    repeat (70) tick();
    chk("ext_byte", 32'(mem[0]), 32'hA5);
    chk("ext_addr", 32'(addr), 32'd1);
    chk("ext_byte_cnt", 32'(byte_cnt), 32'd1);

    // Reset in the middle of the next byte (bit 3)
    s_valid = 1'b1; s_data = 8'h3C;
    tick();
    s_valid = 1'b0;
    repeat (25) tick();
    chk("mid_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    tick();
    chk("midreset_outs", outs(), 32'd0);
    reset_n = 1'b1;
    tick();

    // Recovery frame
    r0 = rst_rises;
    start = 1'b1; pat_en = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_rst", 32'(ser_rst), 32'd1);
    repeat (100) tick();
    chk("restart_byte0", 32'(mem[0]), 32'h00);
    chk("restart_addr", 32'(addr >= 1), 32'd1);
    k = 0;
    while (!frame_done && k < 5000) begin tick(); k++; end
    chk("restart_done", 32'(frame_done), 32'd1);
    tick();
    chk("restart_cnt", 32'(byte_cnt), 32'(FB));
    chk("restart_rsts", 32'(rst_rises - r0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
